// File: rtl/axis_32to8_udp_return.sv
// axis_32to8_udp_return: serialises 32-bit SRIO words MSB-first onto an 8-bit UDP AXIS stream with length restore/check
module axis_32to8_udp_return #(
  parameter bit LEN_CHECK   = 1'b1,
  parameter bit DROP_ORPHAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] axis_tdata_in,
  input  logic        axis_tvalid_in,
  input  logic        axis_tfirst_in,
  input  logic [3:0]  axis_tkeep_in,
  input  logic        axis_tlast_in,
  input  logic [15:0] axis_length_in,
  output logic        axis_tready_out,
  output logic [7:0]  udp_axis_tdata_out,
  output logic        udp_axis_tvalid_out,
  output logic        udp_axis_tlast_out,
  output logic [15:0] udp_axis_tlength_out,
  input  logic        udp_axis_tready_in,
  output logic        len_err
);
  typedef enum logic {IDLE, PKT} st_t;
  st_t         st;
  logic [31:0] hold_data;
  logic        hold_valid, hold_last;
  logic [1:0]  last_idx, byte_idx, keep_idx;
  logic [15:0] byte_cnt;
  logic        fire, word_done, eop, eff_idle, accept, load, open_pkt;
  assign fire      = hold_valid & udp_axis_tready_in;
  assign word_done = fire & (byte_idx == (hold_last ? last_idx : 2'd3));
  assign eop       = word_done & hold_last;
  // a packet finishing this cycle frees the FSM for a back-to-back tfirst beat
  assign eff_idle  = (st == IDLE) | eop;
  assign axis_tready_out = ~reset & (~hold_valid | word_done);
  assign accept    = axis_tvalid_in & axis_tready_out;
  assign load      = accept & (axis_tfirst_in | ~eff_idle | ~DROP_ORPHAN);
  assign open_pkt  = load & (axis_tfirst_in | eff_idle);
  assign udp_axis_tvalid_out = hold_valid;
  assign udp_axis_tlast_out  = hold_valid & hold_last & (byte_idx == last_idx);
  // byte lane select, index 0 is the most significant byte
  always_comb begin
    udp_axis_tdata_out = byte_idx == 2'd0 ? hold_data[31:24] :
                         byte_idx == 2'd1 ? hold_data[23:16] :
                         byte_idx == 2'd2 ? hold_data[15:8]  : hold_data[7:0];
  end
  // last byte index from leading ones of tkeep; empty or broken patterns still emit one byte
  always_comb begin
    keep_idx = ~axis_tkeep_in[3] | ~axis_tkeep_in[2] ? 2'd0 :
               ~axis_tkeep_in[1]                     ? 2'd1 :
               ~axis_tkeep_in[0]                     ? 2'd2 : 2'd3;
  end
  // holding register: load a new word, step through its bytes, empty after its final byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      last_idx   <= '0;
      byte_idx   <= '0;
    end else if (load) begin
      hold_data  <= axis_tdata_in;
      hold_valid <= 1'b1;
      hold_last  <= axis_tlast_in;
      last_idx   <= axis_tlast_in ? keep_idx : 2'd3;
      byte_idx   <= '0;
    end else if (word_done) begin
      hold_valid <= 1'b0;
      byte_idx   <= '0;
    end else if (fire) begin
      byte_idx   <= byte_idx + 2'd1;
    end
  end
  // packet FSM, length capture, byte counting and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st                   <= IDLE;
      udp_axis_tlength_out <= '0;
      byte_cnt             <= '0;
      len_err              <= 1'b0;
    end else begin
      len_err <= (accept & axis_tfirst_in & ~eff_idle) |
                 (LEN_CHECK & eop & (byte_cnt + 16'd1 != udp_axis_tlength_out));
      if (open_pkt) begin
        st                   <= PKT;
        udp_axis_tlength_out <= axis_tfirst_in ? axis_length_in + 16'd1 : 16'd1;
        byte_cnt             <= '0;
      end else begin
        if (eop) st <= IDLE;
        if (fire && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axis_32to8_udp_return.sv
// tb_axis_32to8_udp_return: directed-vector self-checking bench for the 32-to-8 UDP return converter
module tb_axis_32to8_udp_return;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tfirst = 1'b0, tlast = 1'b0;
  logic [3:0]  tkeep = '0;
  logic [15:0] length = '0;
  logic        tready_out;
  logic [7:0]  dout;
  logic        vout, lout, rin, len_err;
  logic [15:0] tlength;
  logic        tog = 1'b0, phase = 1'b0;
  int          pass_n = 0, total_n = 0, errs = 0;
  logic [8:0]  cap[$];
  logic [7:0]  exp_q[$];
  logic        stall = 1'b0;
  logic [8:0]  sv = '0;

  always #5 clk = ~clk;
  always @(posedge clk) phase <= ~phase;
  assign rin = tog ? phase : 1'b1;

  axis_32to8_udp_return dut (
    .clk(clk), .reset(reset),
    .axis_tdata_in(tdata), .axis_tvalid_in(tvalid), .axis_tfirst_in(tfirst),
    .axis_tkeep_in(tkeep), .axis_tlast_in(tlast), .axis_length_in(length),
    .axis_tready_out(tready_out),
    .udp_axis_tdata_out(dout), .udp_axis_tvalid_out(vout), .udp_axis_tlast_out(lout),
    .udp_axis_tlength_out(tlength), .udp_axis_tready_in(rin), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // capture handshaken bytes, count error pulses, and verify outputs hold while stalled
  always @(negedge clk) begin
    if (reset) stall = 1'b0;
    else begin
      if (stall) check("stable", 32'({vout, lout, dout}), 32'({1'b1, sv}));
      if (vout && rin) cap.push_back({lout, dout});
      if (len_err) errs++;
      stall = vout & ~rin;
      sv = {lout, dout};
    end
  end

  task automatic send(input logic [31:0] d, input logic f, input logic l, input logic [3:0] k, input logic [15:0] len);
    tdata = d; tfirst = f; tlast = l; tkeep = k; length = len; tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tready_out) break;
      if (i == 99) check("accept_timeout", 32'(tready_out), 32'd1);
    end
    @(posedge clk); #1;
    tvalid = 1'b0; tfirst = 1'b0; tlast = 1'b0;
  endtask

  task automatic drain();
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic chk_pkt(input string tag, input int exp_errs, input logic [15:0] exp_len);
    logic [8:0] c;
    check({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      c = (i < cap.size()) ? cap[i] : 9'h1FF;
      check($sformatf("%s_byte%0d", tag, i), 32'(c[7:0]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(c[8]), 32'(i == exp_q.size() - 1));
    end
    check({tag, "_len_err"}, 32'(errs), 32'(exp_errs));
    check({tag, "_tlength"}, 32'(tlength), 32'(exp_len));
    check({tag, "_idle"}, 32'(vout), 32'd0);
  endtask

  task automatic pkt1(input logic [15:0] len);
    send(32'h01020304, 1'b1, 1'b0, 4'hF, len);
    send(32'h05060708, 1'b0, 1'b1, 4'hF, len);
  endtask

  initial begin
    #12;
    check("rst_tvalid", 32'(vout), 32'd0);
    check("rst_tready", 32'(tready_out), 32'd0);
    check("rst_tlength", 32'(tlength), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_tready", 32'(tready_out), 32'd1);

    // basic 8-byte packet plus first-byte latency
    cap.delete(); errs = 0;
    send(32'h01020304, 1'b1, 1'b0, 4'hF, 16'd7);
    check("lat_tvalid", 32'(vout), 32'd1);
    check("lat_tdata", 32'(dout), 32'h01);
    send(32'h05060708, 1'b0, 1'b1, 4'hF, 16'd7);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_pkt("t1", 0, 16'd8);

    // partial keep on the last word
    cap.delete(); errs = 0;
    send(32'hAABBCCDD, 1'b1, 1'b0, 4'hF, 16'd5);
    send(32'h11223344, 1'b0, 1'b1, 4'hC, 16'd5);
    drain();
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    chk_pkt("t2", 0, 16'd6);

    // downstream back-pressure toggling every cycle
    cap.delete(); errs = 0; tog = 1'b1;
    pkt1(16'd7);
    drain();
    tog = 1'b0;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_pkt("t3", 0, 16'd8);

    // declared length disagrees with emitted bytes
    cap.delete(); errs = 0;
    pkt1(16'd9);
    drain();
    chk_pkt("t4", 1, 16'd10);

    // orphan beat dropped in IDLE
    cap.delete(); errs = 0;
    send(32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd3);
    pkt1(16'd7);
    drain();
    chk_pkt("t5a", 0, 16'd8);

    // tfirst arriving inside an open packet restarts it
    cap.delete(); errs = 0;
    send(32'h01020304, 1'b1, 1'b0, 4'hF, 16'd7);
    send(32'h0A0B0C0D, 1'b1, 1'b1, 4'hF, 16'd3);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    chk_pkt("t5b", 1, 16'd4);

    // reset in the middle of a packet
    cap.delete(); errs = 0;
    send(32'h01020304, 1'b1, 1'b0, 4'hF, 16'd7);
    tdata = 32'h05060708; tvalid = 1'b1;
    for (int i = 0; i < 50 && cap.size() < 3; i++) @(negedge clk);
    check("t6_pre_bytes", 32'(cap.size()), 32'd3);
    @(posedge clk); #1 reset = 1'b1; tvalid = 1'b0;
    #1;
    check("t6_rst_tvalid", 32'(vout), 32'd0);
    check("t6_rst_tready", 32'(tready_out), 32'd0);
    repeat (2) @(negedge clk);
    check("t6_rst_tready_hold", 32'(tready_out), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    cap.delete(); errs = 0;
    pkt1(16'd7);
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk_pkt("t6", 0, 16'd8);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
